// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi BER test controller.
// Pure package: no logic, no latency, no flow control.
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int CNT_W = 16;

    // PRBS7 x^7 + x^6 + 1: output is s[6], feedback s[6]^s[5] shifts into s[0]
    localparam logic [6:0] PRBS_SEED   = 7'h7F;
    localparam int         PRBS_TAP_HI = 6;
    localparam int         PRBS_TAP_LO = 5;

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/viterbi_ref_delay.sv
// Reference delay line: carries {valid, ref bit} alongside the encoder/decoder path.
// Latency: exactly DEPTH cycles from in_* to out_*.
// Backpressure: none; shifts every cycle, clr drops all valid bits in flight.
module viterbi_ref_delay #(
    parameter int unsigned DEPTH = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_vld,
    input  logic in_dat,
    output logic out_vld,
    output logic out_dat
);

    logic [DEPTH-1:0] vld_sr;
    logic [DEPTH-1:0] dat_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else begin
            vld_sr[0] <= in_vld && !clr;
            dat_sr[0] <= in_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1] && !clr;
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[DEPTH-1];
    assign out_dat = dat_sr[DEPTH-1];

endmodule

// File: rtl/viterbi_ber_ctrl.sv
// BER test controller: feeds PRBS7 frames to an encoder, injects channel errors, scores decoder output.
// Latency: done_o asserts FRAME_LEN+DEC_LAT+1 cycles after start_i is sampled (TAIL_LEN <= DEC_LAT).
// Backpressure: none; the path is free-running, start_i is dropped unless idle/done, abort_i always wins.
module viterbi_ber_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned ERR_PERIOD = 16,
    parameter logic [1:0]  ERR_MASK   = 2'b10,
    parameter int unsigned DEC_LAT    = 24,
    parameter int unsigned TAIL_LEN   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dec_data_i,
    output logic             enc_data_o,
    output logic             enc_enable_o,
    output logic [1:0]       err_inj_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] bit_err_ct_o,
    output logic [CNT_W-1:0] chan_err_ct_o
);

    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_LEN - 1);
    localparam logic [7:0]       PER_LAST   = 8'(ERR_PERIOD - 1);

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       prbs;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] bit_err_ct;
    logic [CNT_W-1:0] chan_err_ct;
    logic [7:0]       per_cnt;
    logic             enc_en;
    logic             enc_dat;
    logic             ref_in_vld;
    logic             ref_out_vld;
    logic             ref_out_dat;
    logic             start_go;
    logic             phase_end;
    logic [1:0]       inj;
    logic [1:0]       inj_pop;

    always_comb begin
        state_nxt  = state;
        enc_en     = 1'b0;
        enc_dat    = 1'b0;
        ref_in_vld = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                enc_en     = 1'b1;
                enc_dat    = prbs[PRBS_TAP_HI];
                ref_in_vld = 1'b1;
                if (phase_cnt == FRAME_LAST) state_nxt = (TAIL_LEN == 0) ? ST_DRAIN : ST_FLUSH;
            end
            ST_FLUSH: begin
                enc_en = 1'b1;
                if (phase_cnt == TAIL_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cmp_cnt == FRAME_CNT) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_i) state_nxt = ST_IDLE;
    end

    assign start_go  = start_i && !abort_i && (state == ST_IDLE || state == ST_DONE);
    assign phase_end = phase_cnt == ((state == ST_RUN) ? FRAME_LAST : TAIL_LAST);
    assign inj       = (enc_en && per_cnt == PER_LAST) ? ERR_MASK : 2'b00;
    assign inj_pop   = {1'b0, inj[1]} + {1'b0, inj[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            prbs        <= PRBS_SEED;
            phase_cnt   <= '0;
            per_cnt     <= '0;
            cmp_cnt     <= '0;
            bit_err_ct  <= '0;
            chan_err_ct <= '0;
        end else begin
            state <= state_nxt;
            if (start_go) begin
                prbs        <= PRBS_SEED;
                phase_cnt   <= '0;
                per_cnt     <= '0;
                cmp_cnt     <= '0;
                bit_err_ct  <= '0;
                chan_err_ct <= '0;
            end else begin
                if (state == ST_RUN) prbs <= prbs_next(prbs);
                if (enc_en) begin
                    phase_cnt <= phase_end ? '0 : phase_cnt + 1'b1;
                    per_cnt   <= (per_cnt == PER_LAST) ? 8'd0 : per_cnt + 8'd1;
                end
                chan_err_ct <= sat_add(chan_err_ct, inj_pop);
                // Counters only move on valid delay-line slots, so idle/abort states hold them
                if (ref_out_vld) begin
                    cmp_cnt    <= cmp_cnt + 1'b1;
                    bit_err_ct <= sat_add(bit_err_ct, {1'b0, ref_out_dat ^ dec_data_i});
                end
            end
        end
    end

    viterbi_ref_delay #(
        .DEPTH (DEC_LAT)
    ) u_ref_delay (
        .clk     (clk),
        .rst     (rst),
        .clr     (abort_i || start_go),
        .in_vld  (ref_in_vld),
        .in_dat  (enc_dat),
        .out_vld (ref_out_vld),
        .out_dat (ref_out_dat)
    );

    assign enc_data_o    = enc_dat;
    assign enc_enable_o  = enc_en;
    assign err_inj_o     = inj;
    assign busy_o        = enc_en;
    assign done_o        = (state == ST_DONE);
    assign bit_err_ct_o  = bit_err_ct;
    assign chan_err_ct_o = chan_err_ct;

endmodule

// File: doc/viterbi_ber_ctrl.md
VITERBI_BER_CTRL -- requirements
Module: viterbi_ber_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256: number of payload bits per test frame (range 1..65535).
REQ-002 SHALL have parameter ERR_PERIOD, default 16: channel symbols per injected error (range 2..255).
REQ-003 SHALL have parameter ERR_MASK, default 2'b10: bits of the symbol inverted at each injection.
REQ-004 SHALL have parameter DEC_LAT, default 24: decoder input-to-output latency in clk cycles (range 1..63).
REQ-005 SHALL have parameter TAIL_LEN, default 2: zero flush bits appended after the payload.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start_i  input  1  begins a test frame.
REQ-009 abort_i  input  1  terminates the frame immediately.
REQ-010 dec_data_i  input  1  decoded bit from the decoder.
REQ-011 enc_data_o  output  1  encoder input bit.
REQ-012 enc_enable_o  output  1  encoder enable.
REQ-013 err_inj_o  output  2  XOR mask the channel applies to the current encoder symbol.
REQ-014 busy_o  output  1  high in RUN or FLUSH.
REQ-015 done_o  output  1  high in DONE.
REQ-016 bit_err_ct_o  output  16  decoded-bit mismatches in the frame.
REQ-017 chan_err_ct_o  output  16  channel bits flipped in the frame.

Function
REQ-018 SHALL implement an FSM with states IDLE, RUN, FLUSH, DRAIN and DONE.
REQ-019 IDLE/DONE: start_i=1 SHALL transition to RUN next cycle, clear both counters, load PRBS seed 7'h7F and clear the error-period counter.
REQ-020 RUN SHALL last exactly FRAME_LEN cycles with enc_enable_o=1 and enc_data_o = PRBS7 output (x^7+x^6+1, output s[6], feedback s[6]^s[5] into s[0], one shift per cycle), then SHALL go to FLUSH.
REQ-021 FLUSH SHALL last TAIL_LEN cycles with enc_enable_o=1 and enc_data_o=0, then SHALL go to DRAIN.
REQ-022 DRAIN SHALL hold enc_enable_o=0 until FRAME_LEN bits have been compared, then SHALL go to DONE.
REQ-023 Error injection: the period counter SHALL increment on every enc_enable_o cycle; err_inj_o SHALL equal ERR_MASK on the cycle the counter equals ERR_PERIOD-1 (counter then wraps to 0) and SHALL be 2'b00 otherwise.
REQ-024 Injection SHALL apply in RUN and FLUSH and SHALL never apply in IDLE, DRAIN or DONE.
REQ-025 chan_err_ct_o SHALL add popcount(err_inj_o) each cycle.
REQ-026 Comparison SHALL use a DEC_LAT-deep delay line of {valid, ref_bit}, with valid=1 only for payload bits in RUN.
REQ-027 When the delay-line output valid=1, bit_err_ct_o SHALL add ref_bit^dec_data_i and the compared-bit count SHALL increment.
REQ-028 Both counters SHALL saturate at 16'hFFFF.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 abort_i in any state SHALL go to IDLE next cycle, deassert enc_enable_o and err_inj_o, clear the delay-line valid bits and hold the counters; abort_i has priority over start_i.
REQ-031 DONE SHALL hold the counters and done_o until start_i or abort_i.

Reset
REQ-032 Reset SHALL force state IDLE and set every output to 0, the PRBS to 7'h7F, the period counter to 0 and all delay-line valid bits to 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame with no done_o pulse.

Structure
REQ-034 Package viterbi_pkg SHALL hold the FSM state enum, the PRBS7 seed/taps constants and the counter width (16).
REQ-035 The delay line SHALL be sub-module viterbi_ref_delay (parameter DEPTH).

Verification
REQ-036 Reset then start_i pulse -> enc_enable_o high for 258 cycles; first 8 enc_data_o bits are 11111110; busy_o falls after FLUSH.
REQ-037 Error-free loopback (dec_data_i = ref delayed 24 cycles) -> done_o set, bit_err_ct_o=0, chan_err_ct_o=16 (258/16 = 16 injections × 1 bit).
REQ-038 ERR_MASK=2'b11, ERR_PERIOD=4 -> chan_err_ct_o = 2×(258/4) = 128; err_inj_o never nonzero outside busy_o.
REQ-039 dec_data_i forced to 0 -> bit_err_ct_o equals the count of ones among the 256 payload PRBS bits.
REQ-040 abort_i at RUN cycle 100 -> IDLE next cycle, enc_enable_o=0, no done_o; a subsequent start_i restarts with cleared counters and seed 7'h7F.
REQ-041 start_i pulsed during RUN and rst asserted during DRAIN -> start_i ignored; on reset all outputs are 0 and done_o never asserts.
